// File: rtl/midi_voice_pkg.sv
// Shared definitions for the polyphonic voice allocator: FSM encoding,
// default widths and the saturation ceiling for the per-voice age counters.
package midi_voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam int DEF_NOTE_W = 7;
  localparam int DEF_AGE_W  = 8;

  // Largest value an age counter of width w may hold (2^w - 1).
  function automatic logic [31:0] age_sat_value(input int w);
    return 32'((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/dffr.sv
// Plain D flop bank with synchronous, active-high clear.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register d every cycle; reset forces zero.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/voice_slot.sv
// One voice: active bit, held note and saturating age counter.
// A grant (set) beats a release (clear); aging only applies to a held voice.
module voice_slot
  import midi_voice_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [NOTE_W-1:0] set_note,
  input  logic              clear,
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] cmp_note,
  output logic              active,
  output logic [NOTE_W-1:0] note,
  output logic [AGE_W-1:0]  age,
  output logic              match
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(age_sat_value(AGE_W));

  logic              active_d;
  logic [NOTE_W-1:0] note_d;
  logic [AGE_W-1:0]  age_d;

  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_SAT) ? a : a + 1'b1;
  endfunction

  // Next-state for the slot: grant, else release, else age while held.
  always_comb begin
    active_d = active;
    note_d   = note;
    age_d    = age;
    if (set) begin
      active_d = 1'b1;
      note_d   = set_note;
      age_d    = '0;
    end else if (clear) begin
      active_d = 1'b0;
      age_d    = '0;
    end else if (age_inc && active) begin
      age_d = sat_inc(age);
    end
  end

  dffr #(.W(1))      u_active (.clk(clk), .reset(reset), .d(active_d), .q(active));
  dffr #(.W(NOTE_W)) u_note   (.clk(clk), .reset(reset), .d(note_d),   .q(note));
  dffr #(.W(AGE_W))  u_age    (.clk(clk), .reset(reset), .d(age_d),    .q(age));

  assign match = active && (note == cmp_note);

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator. A note-on either retriggers the voice already
// holding that note, or round-robin scans one voice per cycle from the
// pointer for a free slot while tracking the oldest busy voice; with no free
// slot the oldest is stolen. Note-off releases matching voices at any time.
module voice_allocator
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 32,
  parameter int VOICE_W    = 5,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int AGE_W      = DEF_AGE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  note_on_valid,
  input  logic [NOTE_W-1:0]     note_on_note,
  output logic                  note_on_ready,
  input  logic                  note_off_valid,
  input  logic [NOTE_W-1:0]     note_off_note,
  output logic                  alloc_valid,
  output logic [VOICE_W-1:0]    alloc_voice,
  output logic [NOTE_W-1:0]     alloc_note,
  output logic                  alloc_stolen,
  output logic                  alloc_retrig,
  output logic [NUM_VOICES-1:0] voices_active
);

  localparam logic [VOICE_W:0]   NV_EXT   = (VOICE_W+1)'(NUM_VOICES);
  localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

  state_t             state, state_n;
  logic [1:0]         state_q;
  logic [VOICE_W-1:0] ptr, ptr_n;
  logic [VOICE_W-1:0] off, off_n;
  logic [VOICE_W-1:0] gnt, gnt_n;
  logic [VOICE_W-1:0] old_idx, old_idx_n;
  logic [AGE_W-1:0]   old_age, old_age_n;
  logic [NOTE_W-1:0]  req_note, req_note_n;
  logic               stolen_q, stolen_n;
  logic               retrig_q, retrig_n;

  logic [NUM_VOICES-1:0] act, match, clr, set_v, inc;
  logic [NOTE_W-1:0]     notes [NUM_VOICES];
  logic [AGE_W-1:0]      ages  [NUM_VOICES];

  logic               grant;
  logic               hit;
  logic [VOICE_W-1:0] hit_idx;
  logic [VOICE_W:0]   scan_sum;
  logic [VOICE_W-1:0] scan_idx;
  logic               cand_take;
  logic [VOICE_W-1:0] cand_idx;
  logic [AGE_W-1:0]   cand_age;

  assign state = state_t'(state_q);
  assign grant = (state == ST_GRANT);

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    assign set_v[g] = grant && (gnt == VOICE_W'(g));
    assign inc[g]   = grant && !set_v[g];
    assign clr[g]   = note_off_valid && act[g] && (notes[g] == note_off_note);

    voice_slot #(.NOTE_W(NOTE_W), .AGE_W(AGE_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .set      (set_v[g]),
      .set_note (req_note),
      .clear    (clr[g]),
      .age_inc  (inc[g]),
      .cmp_note (note_on_note),
      .active   (act[g]),
      .note     (notes[g]),
      .age      (ages[g]),
      .match    (match[g])
    );
  end

  // Lowest-index voice already holding the requested note.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = VOICE_W'(i);
      end
    end
  end

  // Voice under examination, (pointer + offset) mod NUM_VOICES, and the
  // oldest-so-far candidate including it (ties keep the earlier one).
  always_comb begin
    scan_sum = {1'b0, ptr} + {1'b0, off};
    if (scan_sum >= NV_EXT) scan_sum = scan_sum - NV_EXT;
    scan_idx  = scan_sum[VOICE_W-1:0];
    cand_take = (off == '0) || (ages[scan_idx] > old_age);
    cand_idx  = cand_take ? scan_idx : old_idx;
    cand_age  = cand_take ? ages[scan_idx] : old_age;
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    off_n      = off;
    gnt_n      = gnt;
    old_idx_n  = old_idx;
    old_age_n  = old_age;
    req_note_n = req_note;
    stolen_n   = stolen_q;
    retrig_n   = retrig_q;
    case (state)
      ST_IDLE: begin
        if (note_on_valid) begin
          req_note_n = note_on_note;
          stolen_n   = 1'b0;
          if (hit) begin
            gnt_n    = hit_idx;
            retrig_n = 1'b1;
            state_n  = ST_GRANT;
          end else begin
            off_n    = '0;
            retrig_n = 1'b0;
            state_n  = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (!act[scan_idx]) begin
          gnt_n   = scan_idx;
          state_n = ST_GRANT;
        end else begin
          old_idx_n = cand_idx;
          old_age_n = cand_age;
          if (off == LAST_IDX) begin
            gnt_n    = cand_idx;
            stolen_n = 1'b1;
            state_n  = ST_GRANT;
          end else begin
            off_n = off + 1'b1;
          end
        end
      end
      ST_GRANT: begin
        state_n = ST_IDLE;
        if (!retrig_q) ptr_n = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  dffr #(.W(2))       u_state  (.clk(clk), .reset(reset), .d(state_n),    .q(state_q));
  dffr #(.W(VOICE_W)) u_ptr    (.clk(clk), .reset(reset), .d(ptr_n),      .q(ptr));
  dffr #(.W(VOICE_W)) u_off    (.clk(clk), .reset(reset), .d(off_n),      .q(off));
  dffr #(.W(VOICE_W)) u_gnt    (.clk(clk), .reset(reset), .d(gnt_n),      .q(gnt));
  dffr #(.W(VOICE_W)) u_oldidx (.clk(clk), .reset(reset), .d(old_idx_n),  .q(old_idx));
  dffr #(.W(AGE_W))   u_oldage (.clk(clk), .reset(reset), .d(old_age_n),  .q(old_age));
  dffr #(.W(NOTE_W))  u_note   (.clk(clk), .reset(reset), .d(req_note_n), .q(req_note));
  dffr #(.W(1))       u_stolen (.clk(clk), .reset(reset), .d(stolen_n),   .q(stolen_q));
  dffr #(.W(1))       u_retrig (.clk(clk), .reset(reset), .d(retrig_n),   .q(retrig_q));

  assign note_on_ready = (state == ST_IDLE) && !reset;
  assign alloc_valid   = grant;
  assign alloc_voice   = grant ? gnt : '0;
  assign alloc_note    = grant ? req_note : '0;
  assign alloc_stolen  = grant && stolen_q;
  assign alloc_retrig  = grant && retrig_q;
  assign voices_active = act;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator (4 voices): directed scenarios plus randomized
// note-on/note-off traffic, every cycle compared with a voice-table model.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int VW = 2;
  localparam int NW = 7;
  localparam int AW = 8;
  localparam int AGE_MAX = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          on_v;
  logic [NW-1:0] on_n;
  logic          ready;
  logic          off_v;
  logic [NW-1:0] off_n;
  logic          a_valid;
  logic [VW-1:0] a_voice;
  logic [NW-1:0] a_note;
  logic          a_stolen;
  logic          a_retrig;
  logic [NV-1:0] vact;

  voice_allocator #(.NUM_VOICES(NV), .VOICE_W(VW), .NOTE_W(NW), .AGE_W(AW)) dut (
    .clk(clk), .reset(reset),
    .note_on_valid(on_v), .note_on_note(on_n), .note_on_ready(ready),
    .note_off_valid(off_v), .note_off_note(off_n),
    .alloc_valid(a_valid), .alloc_voice(a_voice), .alloc_note(a_note),
    .alloc_stolen(a_stolen), .alloc_retrig(a_retrig), .voices_active(vact)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference voice table and pending request
  bit m_act [NV];
  int m_note[NV];
  int m_age [NV];
  int m_ptr = 0;
  bit m_busy = 0;
  bit m_scan = 0;
  int m_scan0 = 0;
  int m_old = 0;
  int m_old_age = 0;
  int g_cycle = -1;
  int g_voice = 0;
  int g_note = 0;
  int g_stolen = 0;
  int g_retrig = 0;

  // last observed outputs
  bit obs_valid, obs_ready, obs_st, obs_rt;
  int obs_voice, obs_note, obs_vact;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_note[v] = 0; m_age[v] = 0;
    end
    m_ptr = 0; m_busy = 0; m_scan = 0; g_cycle = -1;
  endtask

  task automatic model_step(input bit r, input bit ov, input int onn, input bit fv, input int fn);
    bit n_act [NV];
    int n_note[NV];
    int n_age [NV];
    bit grant_now;
    int i, v, hit;
    if (r) begin
      model_reset();
      return;
    end
    grant_now = (g_cycle == cyc);
    if (m_scan) begin
      i = cyc - m_scan0;
      v = (m_ptr + i) % NV;
      if (!m_act[v]) begin
        g_cycle = cyc + 1; g_voice = v; g_stolen = 0; g_retrig = 0; m_scan = 0;
      end else begin
        if (i == 0 || m_age[v] > m_old_age) begin
          m_old = v; m_old_age = m_age[v];
        end
        if (i == NV - 1) begin
          g_cycle = cyc + 1; g_voice = m_old; g_stolen = 1; g_retrig = 0; m_scan = 0;
        end
      end
    end
    if (!m_busy && ov) begin
      m_busy = 1;
      g_note = onn;
      hit = -1;
      for (int k = 0; k < NV; k++)
        if (hit < 0 && m_act[k] && m_note[k] == onn) hit = k;
      if (hit >= 0) begin
        g_cycle = cyc + 1; g_voice = hit; g_retrig = 1; g_stolen = 0;
      end else begin
        m_scan = 1; m_scan0 = cyc + 1;
      end
    end
    for (int k = 0; k < NV; k++) begin
      n_act[k] = m_act[k]; n_note[k] = m_note[k]; n_age[k] = m_age[k];
      if (fv && m_act[k] && m_note[k] == fn) begin
        n_act[k] = 0; n_age[k] = 0;
      end
    end
    if (grant_now) begin
      for (int k = 0; k < NV; k++)
        if (k != g_voice && n_act[k])
          n_age[k] = (m_age[k] >= AGE_MAX) ? AGE_MAX : m_age[k] + 1;
      n_act[g_voice] = 1; n_note[g_voice] = g_note; n_age[g_voice] = 0;
      if (!g_retrig) m_ptr = (g_voice + 1) % NV;
      m_busy = 0;
    end
    for (int k = 0; k < NV; k++) begin
      m_act[k] = n_act[k]; m_note[k] = n_note[k]; m_age[k] = n_age[k];
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic tick(input bit r, input bit ov, input int onn, input bit fv, input int fn);
    logic [NV-1:0] mask;
    bit exp_valid;
    reset = r; on_v = ov; on_n = NW'(onn); off_v = fv; off_n = NW'(fn);
    #1;
    obs_valid = a_valid; obs_ready = ready; obs_voice = int'(a_voice);
    obs_note = int'(a_note); obs_st = a_stolen; obs_rt = a_retrig; obs_vact = int'(vact);
    for (int k = 0; k < NV; k++) mask[k] = m_act[k];
    exp_valid = (g_cycle == cyc);
    chk("ready", ready, !m_busy && !r);
    chk("valid", a_valid, exp_valid);
    if (exp_valid) begin
      chk("voice", a_voice, g_voice);
      chk("note", a_note, g_note);
      chk("stolen", a_stolen, g_stolen);
      chk("retrig", a_retrig, g_retrig);
    end else begin
      chk("idle_flags", {a_stolen, a_retrig}, 0);
    end
    chk("active", vact, mask);
    model_step(r, ov, onn, fv, fn);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
  endtask

  // Issue a note-on and check latency and grant fields against fixed values.
  task automatic expect_grant(input string tag, input int note, input int e_lat,
                              input int e_voice, input bit e_st, input bit e_rt);
    int t0, lat;
    t0 = cyc;
    lat = -1;
    tick(0, 1, note, 0, 0);
    for (int n = 0; n < 40 && lat < 0; n++) begin
      tick(0, 0, 0, 0, 0);
      if (obs_valid) lat = cyc - 1 - t0;
    end
    chk({tag, "_lat"}, lat, e_lat);
    if (lat >= 0) begin
      chk({tag, "_voice"}, obs_voice, e_voice);
      chk({tag, "_note"}, obs_note, note);
      chk({tag, "_stolen"}, obs_st, e_st);
      chk({tag, "_retrig"}, obs_rt, e_rt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int vcount;
    reset = 1; on_v = 0; on_n = '0; off_v = 0; off_n = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // first allocation after reset
    do_reset();
    chk("rst_active", obs_vact, 0);
    chk("rst_ready_low", obs_ready, 0);
    expect_grant("first", 60, 2, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk("first_mask", obs_vact, 1);

    // round robin, release, pointer wrap
    expect_grant("rr62", 62, 2, 1, 0, 0);
    expect_grant("rr64", 64, 2, 2, 0, 0);
    tick(0, 0, 0, 1, 62);
    expect_grant("rr65", 65, 2, 3, 0, 0);
    expect_grant("rr67", 67, 3, 1, 0, 0);

    // full table: steal the oldest, then retrigger without moving the pointer
    do_reset();
    expect_grant("f60", 60, 2, 0, 0, 0);
    expect_grant("f62", 62, 2, 1, 0, 0);
    expect_grant("f64", 64, 2, 2, 0, 0);
    expect_grant("f65", 65, 2, 3, 0, 0);
    expect_grant("steal", 70, 5, 0, 1, 0);
    expect_grant("retrig", 64, 1, 2, 0, 1);
    tick(0, 0, 0, 1, 62);
    expect_grant("after_retrig", 71, 2, 1, 0, 0);

    // note-off colliding with the grant of the same note
    do_reset();
    tick(0, 1, 60, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 60);
    chk("gvo_valid", obs_valid, 1);
    chk("gvo_voice", obs_voice, 0);
    tick(0, 0, 0, 0, 0);
    chk("gvo_active", obs_vact, 1);
    tick(0, 0, 0, 1, 99);
    tick(0, 0, 0, 0, 0);
    chk("absent_off", obs_vact, 1);

    // reset in the middle of a full scan aborts the request
    do_reset();
    expect_grant("m60", 60, 2, 0, 0, 0);
    expect_grant("m62", 62, 2, 1, 0, 0);
    expect_grant("m64", 64, 2, 2, 0, 0);
    expect_grant("m65", 65, 2, 3, 0, 0);
    tick(0, 1, 70, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    vcount = 0;
    for (int n = 0; n < 6; n++) begin
      tick(0, 0, 0, 0, 0);
      if (n == 0) begin
        chk("abort_active", obs_vact, 0);
        chk("abort_ready", obs_ready, 1);
      end
      vcount += int'(obs_valid);
    end
    chk("abort_no_grant", vcount, 0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      tick($urandom_range(0, 249) == 0,
           $urandom_range(0, 1) == 1,
           60 + int'($urandom_range(0, 5)),
           $urandom_range(0, 3) == 0,
           60 + int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
